// File: rtl/timer_pkg.sv
// Shared types and helpers for the egg-timer datapath.
package timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX    = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

    function automatic bcd_t bcd_clamp(input bcd_t d, input bcd_t max_d);
        return (d > max_d) ? max_d : d;
    endfunction

endpackage

// File: rtl/timer_tick_gen.sv
// Enable-gated modulo-N counter; wrap pulses in the cycle the count sits at N-1.
module timer_tick_gen #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt;

    assign wrap = en && (cnt == LAST);

    // Dropping the enable discards any partial count.
    always_ff @(posedge clk) begin
        if (reset || clr || !en) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_datapath.sv
// MM:SS BCD time store for the egg timer: switch loads, 1 Hz countdown, flash strobe.
module timer_datapath
    import timer_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int FLASH_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       initValEn,
    input  logic       timeWrtEn,
    input  logic       minEn,
    input  logic       decEn,
    input  logic       flashEn,
    input  logic [7:0] valIn,
    output logic [3:0] minTens,
    output logic [3:0] minOnes,
    output logic [3:0] secTens,
    output logic [3:0] secOnes,
    output logic       isTimeFlat,
    output logic       blank
);

    logic sec_tick;
    logic flash_wrap;
    logic phase;
    bcd_t dec_mt, dec_mo, dec_st, dec_so;

    timer_tick_gen #(.N(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (decEn),
        .clr   (initValEn | timeWrtEn),
        .wrap  (sec_tick)
    );

    timer_tick_gen #(.N(FLASH_DIV)) u_flash_div (
        .clk   (clk),
        .reset (reset),
        .en    (flashEn),
        .clr   (1'b0),
        .wrap  (flash_wrap)
    );

    assign isTimeFlat = (minTens == 4'd0) && (minOnes == 4'd0) &&
                        (secTens == 4'd0) && (secOnes == 4'd0);

    // One-second borrow chain; only applied when the time is not already 00:00.
    always_comb begin
        dec_mt = minTens;
        dec_mo = minOnes;
        dec_st = secTens;
        dec_so = secOnes;
        if (secOnes != 4'd0) begin
            dec_so = secOnes - 4'd1;
        end else begin
            dec_so = DIGIT_MAX;
            if (secTens != 4'd0) begin
                dec_st = secTens - 4'd1;
            end else begin
                dec_st = SEC_TENS_MAX;
                if (minOnes != 4'd0) begin
                    dec_mo = minOnes - 4'd1;
                end else begin
                    dec_mo = DIGIT_MAX;
                    dec_mt = minTens - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || initValEn) begin
            minTens <= 4'd0;
            minOnes <= 4'd0;
            secTens <= 4'd0;
            secOnes <= 4'd0;
        end else if (timeWrtEn) begin
            if (minEn) begin
                minTens <= bcd_clamp(valIn[7:4], DIGIT_MAX);
                minOnes <= bcd_clamp(valIn[3:0], DIGIT_MAX);
            end else begin
                secTens <= bcd_clamp(valIn[7:4], SEC_TENS_MAX);
                secOnes <= bcd_clamp(valIn[3:0], DIGIT_MAX);
            end
        end else if (sec_tick && !isTimeFlat) begin
            minTens <= dec_mt;
            minOnes <= dec_mo;
            secTens <= dec_st;
            secOnes <= dec_so;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !flashEn) begin
            phase <= 1'b0;
        end else if (flash_wrap) begin
            phase <= ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blank <= 1'b0;
        end else begin
            blank <= flashEn & phase;
        end
    end

endmodule

// File: tb/tb_timer_datapath.sv
// Scenario bench for timer_datapath with TICK_DIV=4, FLASH_DIV=2.
module tb_timer_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       initValEn = 1'b0;
    logic       timeWrtEn = 1'b0;
    logic       minEn = 1'b0;
    logic       decEn = 1'b0;
    logic       flashEn = 1'b0;
    logic [7:0] valIn = 8'h00;
    logic [3:0] minTens, minOnes, secTens, secOnes;
    logic       isTimeFlat;
    logic       blank;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_t[$];
    logic        exp_b[$];
    logic [15:0] et;
    logic        eb;

    timer_datapath #(.TICK_DIV(4), .FLASH_DIV(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .initValEn  (initValEn),
        .timeWrtEn  (timeWrtEn),
        .minEn      (minEn),
        .decEn      (decEn),
        .flashEn    (flashEn),
        .valIn      (valIn),
        .minTens    (minTens),
        .minOnes    (minOnes),
        .secTens    (secTens),
        .secOnes    (secOnes),
        .isTimeFlat (isTimeFlat),
        .blank      (blank)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {minTens, minOnes, secTens, secOnes};
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic write_field(input logic m, input logic [7:0] v);
        timeWrtEn = 1'b1;
        minEn     = m;
        valIn     = v;
        step();
        timeWrtEn = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(3);
        exp_t.push_back(16'h0000);
        et = exp_t.pop_front();
        n_cmp++;
        if (digits() !== et) begin
            n_bad++;
            $display("FAIL reset_digits got %h want %h", digits(), et);
        end
        n_cmp++;
        if (isTimeFlat !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_flat got %b want 1", isTimeFlat);
        end
        n_cmp++;
        if (blank !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_blank got %b want 0", blank);
        end
    endtask

    task automatic test_write();
        logic [7:0] vals[4] = '{8'h12, 8'h05, 8'h7C, 8'hAB};
        logic       mins[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] exps[4] = '{16'h1200, 16'h1205, 16'h1259, 16'h9959};
        for (int i = 0; i < 4; i++) begin
            exp_t.push_back(exps[i]);
            write_field(mins[i], vals[i]);
            et = exp_t.pop_front();
            n_cmp++;
            if (digits() !== et) begin
                n_bad++;
                $display("FAIL write_%0d got %h want %h", i, digits(), et);
            end
            n_cmp++;
            if (isTimeFlat !== 1'b0) begin
                n_bad++;
                $display("FAIL write_flat_%0d got %b want 0", i, isTimeFlat);
            end
        end
    endtask

    task automatic test_countdown();
        // Plain run: 10:00 -> 09:59 at edge 4, 09:58 at edge 8.
        write_field(1'b1, 8'h10);
        write_field(1'b0, 8'h00);
        decEn = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            exp_t.push_back(e < 4 ? 16'h1000 : (e < 8 ? 16'h0959 : 16'h0958));
            step();
            et = exp_t.pop_front();
            n_cmp++;
            if (digits() !== et) begin
                n_bad++;
                $display("FAIL countdown_e%0d got %h want %h", e, digits(), et);
            end
        end
        // Pause at edge 6 discards the partial second.
        decEn = 1'b0;
        write_field(1'b1, 8'h10);
        write_field(1'b0, 8'h00);
        decEn = 1'b1;
        step(5);
        decEn = 1'b0;
        step();
        decEn = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            exp_t.push_back(e < 4 ? 16'h0959 : 16'h0958);
            step();
            et = exp_t.pop_front();
            n_cmp++;
            if (digits() !== et) begin
                n_bad++;
                $display("FAIL pause_e%0d got %h want %h", e, digits(), et);
            end
        end
        // Write with decEn high two edges into a second restarts the prescaler.
        step(2);
        write_field(1'b0, 8'h30);
        for (int e = 1; e <= 4; e++) begin
            exp_t.push_back(e < 4 ? 16'h0930 : 16'h0929);
            step();
            et = exp_t.pop_front();
            n_cmp++;
            if (digits() !== et) begin
                n_bad++;
                $display("FAIL wrt_dec_e%0d got %h want %h", e, digits(), et);
            end
        end
        decEn = 1'b0;
    endtask

    task automatic test_borrow();
        // 10:00 -> 09:59 already covers the full chain; check 01:00 and 00:10 too.
        logic [7:0]  mv[2] = '{8'h01, 8'h00};
        logic [7:0]  sv[2] = '{8'h00, 8'h10};
        logic [15:0] ev[2] = '{16'h0059, 16'h0009};
        for (int i = 0; i < 2; i++) begin
            write_field(1'b1, mv[i]);
            write_field(1'b0, sv[i]);
            exp_t.push_back(ev[i]);
            decEn = 1'b1;
            step(4);
            decEn = 1'b0;
            et = exp_t.pop_front();
            n_cmp++;
            if (digits() !== et) begin
                n_bad++;
                $display("FAIL borrow_%0d got %h want %h", i, digits(), et);
            end
        end
    endtask

    task automatic test_flat_hold();
        write_field(1'b1, 8'h00);
        write_field(1'b0, 8'h02);
        decEn = 1'b1;
        for (int e = 1; e <= 28; e++) begin
            exp_t.push_back(e < 4 ? 16'h0002 : (e < 8 ? 16'h0001 : 16'h0000));
            step();
            et = exp_t.pop_front();
            n_cmp++;
            if (digits() !== et) begin
                n_bad++;
                $display("FAIL flat_e%0d got %h want %h", e, digits(), et);
            end
            n_cmp++;
            if (isTimeFlat !== (e >= 8)) begin
                n_bad++;
                $display("FAIL flat_flag_e%0d got %b want %b", e, isTimeFlat, e >= 8);
            end
        end
        decEn = 1'b0;
    endtask

    task automatic test_flash();
        logic pat[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        flashEn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_b.push_back(pat[i]);
            if (i > 0) step();
            eb = exp_b.pop_front();
            n_cmp++;
            if (blank !== eb) begin
                n_bad++;
                $display("FAIL flash_%0d got %b want %b", i, blank, eb);
            end
        end
        flashEn = 1'b0;
        step();
        n_cmp++;
        if (blank !== 1'b0) begin
            n_bad++;
            $display("FAIL flash_off got %b want 0", blank);
        end
        // Drop while blank is high.
        flashEn = 1'b1;
        step(3);
        n_cmp++;
        if (blank !== 1'b1) begin
            n_bad++;
            $display("FAIL flash_rearm got %b want 1", blank);
        end
        flashEn = 1'b0;
        step();
        n_cmp++;
        if (blank !== 1'b0) begin
            n_bad++;
            $display("FAIL flash_drop got %b want 0", blank);
        end
    endtask

    task automatic test_init_reset();
        write_field(1'b1, 8'h03);
        write_field(1'b0, 8'h30);
        decEn = 1'b1;
        step(2);
        initValEn = 1'b1;
        timeWrtEn = 1'b1;
        minEn     = 1'b1;
        valIn     = 8'h45;
        exp_t.push_back(16'h0000);
        step();
        initValEn = 1'b0;
        timeWrtEn = 1'b0;
        et = exp_t.pop_front();
        n_cmp++;
        if (digits() !== et) begin
            n_bad++;
            $display("FAIL init_clear got %h want %h", digits(), et);
        end
        write_field(1'b1, 8'h03);
        write_field(1'b0, 8'h30);
        flashEn = 1'b1;
        step(3);
        reset     = 1'b1;
        timeWrtEn = 1'b1;
        minEn     = 1'b1;
        valIn     = 8'h45;
        exp_t.push_back(16'h0000);
        step();
        et = exp_t.pop_front();
        n_cmp++;
        if (digits() !== et) begin
            n_bad++;
            $display("FAIL reset_mid got %h want %h", digits(), et);
        end
        n_cmp++;
        if (blank !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_blank got %b want 0", blank);
        end
        reset     = 1'b0;
        timeWrtEn = 1'b0;
        flashEn   = 1'b0;
        decEn     = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_countdown();
        test_borrow();
        test_flat_hold();
        test_flash();
        test_init_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
